game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter OVERLAP_MIN, default 4: overlapping pixel count per frame at or above which a collision is declared.
REQ-002 SHALL have parameter SCORE_DIV, default 6: number of running frames per score increment.
REQ-003 SHALL have port clkdiv  input  1  pixel clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port START  input  1  level start/restart request; only its rising edge acts.
REQ-006 SHALL have port fresh  input  1  frame strobe; a 1->0 transition marks end of frame.
REQ-007 SHALL have port video_on  input  1  high while the current pixel is in the visible area.
REQ-008 SHALL have port dino_px  input  1  dinosaur sprite pixel, one registered clkdiv cycle after address.
REQ-009 SHALL have port obst_px  input  1  obstacle sprite pixel, same latency as dino_px.
REQ-010 SHALL have port game_status  output  1  high only in RUN; consumed by the jump and obstacle stages.
REQ-011 SHALL have port game_over  output  1  high only in OVER.
REQ-012 SHALL have port score  output  16  four BCD digits, [15:12] thousands through [3:0] units.

Function
REQ-013 SHALL register fresh and START each cycle; frame_end = previous fresh 1 and current fresh 0; start_edge = previous START 0 and current START 1.
REQ-014 SHALL implement a three-state FSM: IDLE, RUN and OVER.
REQ-015 SHALL drive game_status=1 in RUN only and game_over=1 in OVER only, both as decoded registered state, with no extra latency.
REQ-016 SHALL transition IDLE->RUN on start_edge, clearing score, the frame divider and the overlap counter.
REQ-017 SHALL transition OVER->RUN on start_edge, with the same clears as REQ-016.
REQ-018 SHALL ignore start_edge in RUN.
REQ-019 SHALL keep an 8-bit overlap counter that, in RUN, increments on every cycle with video_on & dino_px & obst_px and saturates at 255.
REQ-020 SHALL hold the overlap counter at 0 outside RUN.
REQ-021 SHALL clear the overlap counter on every frame_end, after its value has been evaluated in that cycle.
REQ-022 SHALL, at frame_end in RUN, declare a collision if the overlap count, including any increment in the same cycle, is >= OVERLAP_MIN; RUN->OVER occurs on the next edge.
REQ-023 SHALL, in RUN, advance a frame divider (0..SCORE_DIV-1) on each frame_end without collision; on wrap from SCORE_DIV-1 to 0 the score increments by 1.
REQ-024 SHALL keep score in BCD: each digit wraps 9->0 with carry into the next digit; at 9999 the score saturates and does not wrap.
REQ-025 SHALL, when a collision and a divider wrap occur on the same frame_end, give priority to the collision: the score does not increment and the divider holds.
REQ-026 SHALL hold score and the divider unchanged in IDLE and OVER, so the final score remains visible in OVER.
REQ-027 SHALL, when start_edge and frame_end coincide in IDLE or OVER, give priority to start: enter RUN with all clears applied and ignore that frame_end.

Reset
REQ-028 SHALL, on RESET asserted at any time including mid-frame in RUN, immediately enter IDLE and set game_status=0, game_over=0, score=16'h0000, divider=0, overlap counter=0, and both edge-detect registers to 0.
REQ-029 SHALL, after RESET deasserts, require a fresh start_edge before entering RUN; a START held high through reset does not start the game.

Verification
REQ-030 SHALL verify: RESET, then START pulsed -> game_status=1 one cycle after the edge detect, score=0000.
REQ-031 SHALL verify: in RUN, 12 frames with no overlap (SCORE_DIV=6) -> score=0002, game_status stays 1.
REQ-032 SHALL verify: 3 overlapping pixels in a frame -> no collision; 4 overlapping pixels -> game_over=1 and game_status=0 one cycle after that frame_end; score is frozen.
REQ-033 SHALL verify: score preloaded to 0009 with divider at 5, clean frame_end -> score=0010; preloaded to 9999 -> remains 9999.
REQ-034 SHALL verify: collision on the same frame_end as a divider wrap -> OVER entered, score unchanged; then START edge -> RUN with score=0000.
REQ-035 SHALL verify: RESET asserted mid-frame in RUN while START is held high -> IDLE with all outputs at 0 and no restart until START falls and rises again.

Source files
------------

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - game state machine: start/collision control and BCD score keeping
module game_ctrl #(
    parameter int OVERLAP_MIN = 4,
    parameter int SCORE_DIV   = 6
) (
    input  logic        clkdiv,
    input  logic        RESET,
    input  logic        START,
    input  logic        fresh,
    input  logic        video_on,
    input  logic        dino_px,
    input  logic        obst_px,
    output logic        game_status,
    output logic        game_over,
    output logic [15:0] score
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    localparam int DIV_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCORE_DIV - 1);

    logic [1:0]       state;
    logic             fresh_d;
    logic             start_d;
    logic             start_armed;
    logic [7:0]       ovl_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [15:0]      score_q;

    logic             frame_end;
    logic             start_edge;
    logic             hit;
    logic [7:0]       ovl_eval;
    logic             collision;
    logic             div_wrap;

    // Start is only honoured once START has been seen low after reset,
    // so a button held through reset cannot launch a game.
    assign frame_end  = fresh_d & ~fresh;
    assign start_edge = start_armed & ~start_d & START;
    assign hit        = video_on & dino_px & obst_px;
    assign ovl_eval   = (hit && ovl_cnt != 8'hFF) ? ovl_cnt + 8'd1 : ovl_cnt;
    assign collision  = frame_end && ({24'd0, ovl_eval} >= 32'(OVERLAP_MIN));
    assign div_wrap   = (div_cnt == DIV_LAST);

    assign game_status = (state == S_RUN);
    assign game_over   = (state == S_OVER);
    assign score       = score_q;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clkdiv or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            fresh_d     <= 1'b0;
            start_d     <= 1'b0;
            start_armed <= 1'b0;
            ovl_cnt     <= 8'd0;
            div_cnt     <= '0;
            score_q     <= 16'h0000;
        end else begin
            fresh_d <= fresh;
            start_d <= START;
            if (!START) begin
                start_armed <= 1'b1;
            end
            case (state)
                S_IDLE, S_OVER: begin
                    ovl_cnt <= 8'd0;
                    if (start_edge) begin
                        state   <= S_RUN;
                        div_cnt <= '0;
                        score_q <= 16'h0000;
                    end
                end
                S_RUN: begin
                    if (frame_end) begin
                        ovl_cnt <= 8'd0;
                        if (collision) begin
                            state <= S_OVER;
                        end else if (div_wrap) begin
                            div_cnt <= '0;
                            if (score_q != 16'h9999) begin
                                score_q <= bcd_inc(score_q);
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end else begin
                        ovl_cnt <= ovl_eval;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ovl_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - randomized and directed bench for game_ctrl against a frame-level model
module tb_game_ctrl;

    localparam int OMIN = 4;
    localparam int SDIV = 6;

    logic        clkdiv = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        fresh = 1'b0;
    logic        video_on = 1'b0;
    logic        dino_px = 1'b0;
    logic        obst_px = 1'b0;
    logic        game_status;
    logic        game_over;
    logic [15:0] score;

    logic        fresh2 = 1'b0;
    logic        sat_status;
    logic        sat_over;
    logic [15:0] sat_score;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clkdiv = ~clkdiv;

    game_ctrl #(.OVERLAP_MIN(OMIN), .SCORE_DIV(SDIV)) dut (
        .clkdiv(clkdiv), .RESET(RESET), .START(START), .fresh(fresh),
        .video_on(video_on), .dino_px(dino_px), .obst_px(obst_px),
        .game_status(game_status), .game_over(game_over), .score(score)
    );

    game_ctrl #(.OVERLAP_MIN(OMIN), .SCORE_DIV(1)) u_sat (
        .clkdiv(clkdiv), .RESET(RESET), .START(START), .fresh(fresh2),
        .video_on(video_on), .dino_px(1'b0), .obst_px(1'b0),
        .game_status(sat_status), .game_over(sat_over), .score(sat_score)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 run, 2 over; score follows from clean frames since start.
    int m_mode = 0;
    int m_clean = 0;
    int m_ovl = 0;
    bit m_pf = 0;
    bit m_ps = 0;
    bit m_sv = 0;

    always @(posedge clkdiv or posedge RESET) begin
        bit fe;
        bit se;
        if (RESET) begin
            m_mode = 0; m_clean = 0; m_ovl = 0;
            m_pf = 0; m_ps = 0; m_sv = 0;
        end else begin
            fe = m_pf && !fresh;
            se = m_sv && !m_ps && START;
            if (m_mode == 1) begin
                if (video_on && dino_px && obst_px) m_ovl = m_ovl + 1;
                if (m_ovl > 255) m_ovl = 255;
                if (fe) begin
                    if (m_ovl >= OMIN) m_mode = 2;
                    else m_clean = m_clean + 1;
                    m_ovl = 0;
                end
            end else begin
                m_ovl = 0;
                if (se) begin
                    m_mode = 1;
                    m_clean = 0;
                end
            end
            m_pf = fresh;
            m_ps = START;
            m_sv = 1;
        end
    end

    function automatic logic [15:0] to_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000 % 10), 4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10)};
    endfunction

    always @(negedge clkdiv) begin
        if (chk_on) begin
            chk("status", 16'(game_status), 16'(m_mode == 1));
            chk("over", 16'(game_over), 16'(m_mode == 2));
            chk("score", score, to_bcd(m_clean / SDIV));
        end
    end

    task automatic cyc();
        @(posedge clkdiv);
        #1;
    endtask

    task automatic noise_px();
        video_on = 1'($urandom % 2);
        dino_px  = 1'($urandom % 2);
        obst_px  = (video_on && dino_px) ? 1'b0 : 1'($urandom % 2);
    endtask

    // Body of 12 visible cycles, 2 blanking cycles, then the frame_end cycle.
    task automatic frame(input int hits, input bit end_hit);
        fresh = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c < hits) begin
                video_on = 1'b1; dino_px = 1'b1; obst_px = 1'b1;
            end else begin
                noise_px();
            end
            cyc();
        end
        fresh = 1'b1;
        video_on = 1'b0; dino_px = 1'b0; obst_px = 1'b0;
        cyc();
        cyc();
        fresh = 1'b0;
        video_on = end_hit; dino_px = end_hit; obst_px = end_hit;
        cyc();
        video_on = 1'b0; dino_px = 1'b0; obst_px = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        cyc(); cyc(); cyc();
        chk_on = 1'b1;
        chk("rst_status", 16'(game_status), 16'd0);
        chk("rst_over", 16'(game_over), 16'd0);
        chk("rst_score", score, 16'h0000);
        RESET = 1'b0;
        cyc();

        START = 1'b1; cyc();
        chk("start_status", 16'(game_status), 16'd1);
        chk("start_score", score, 16'h0000);
        START = 1'b0; cyc();

        for (int f = 0; f < 12; f++) frame(0, 1'b0);
        chk("12f_score", score, 16'h0002);
        chk("12f_status", 16'(game_status), 16'd1);

        frame(3, 1'b0);
        chk("ovl3_status", 16'(game_status), 16'd1);
        frame(3, 1'b1);
        chk("ovl4_over", 16'(game_over), 16'd1);
        chk("ovl4_status", 16'(game_status), 16'd0);
        chk("ovl4_score", score, 16'h0002);
        frame(0, 1'b0); frame(0, 1'b0);
        chk("frozen_score", score, 16'h0002);

        START = 1'b1; cyc(); START = 1'b0; cyc();
        chk("restart_status", 16'(game_status), 16'd1);
        chk("restart_score", score, 16'h0000);
        for (int f = 0; f < 59; f++) frame(0, 1'b0);
        chk("score_0009", score, 16'h0009);
        frame(0, 1'b0);
        chk("score_0010", score, 16'h0010);
        for (int f = 0; f < 5; f++) frame(0, 1'b0);
        frame(4, 1'b0);
        chk("wrapcol_over", 16'(game_over), 16'd1);
        chk("wrapcol_score", score, 16'h0010);

        fresh = 1'b1; cyc(); cyc();
        fresh = 1'b0; START = 1'b1; cyc();
        chk("coinc_status", 16'(game_status), 16'd1);
        chk("coinc_score", score, 16'h0000);
        START = 1'b0; cyc();
        for (int f = 0; f < 5; f++) frame(0, 1'b0);
        chk("coinc_fe_ignored", score, 16'h0000);
        frame(0, 1'b0);
        chk("coinc_6f", score, 16'h0001);

        START = 1'b1;
        fresh = 1'b0;
        for (int c = 0; c < 4; c++) begin
            video_on = 1'b1; dino_px = 1'b1; obst_px = 1'b1;
            cyc();
        end
        chk("start_ignored_run", 16'(game_status), 16'd1);
        @(posedge clkdiv);
        #3 RESET = 1'b1;
        #1;
        chk("async_status", 16'(game_status), 16'd0);
        chk("async_over", 16'(game_over), 16'd0);
        chk("async_score", score, 16'h0000);
        video_on = 1'b0; dino_px = 1'b0; obst_px = 1'b0;
        cyc(); cyc();
        RESET = 1'b0;
        for (int c = 0; c < 4; c++) cyc();
        chk("held_start_no_run", 16'(game_status), 16'd0);
        START = 1'b0; cyc();
        START = 1'b1; cyc();
        chk("fresh_start_run", 16'(game_status), 16'd1);
        START = 1'b0; cyc();

        for (int f = 0; f < 200; f++) begin
            int body;
            body = 4 + int'($urandom % 20);
            fresh = 1'b0;
            for (int c = 0; c < body; c++) begin
                video_on = ($urandom % 4) != 0;
                dino_px  = 1'($urandom % 2);
                obst_px  = 1'($urandom % 2);
                if ($urandom % 30 == 0) START = ~START;
                if ($urandom % 600 == 0) begin
                    @(posedge clkdiv);
                    #3 RESET = 1'b1;
                    cyc();
                    RESET = 1'b0;
                end
                cyc();
            end
            fresh = 1'b1;
            for (int c = 0; c < 1 + int'($urandom % 2); c++) begin
                noise_px();
                cyc();
            end
        end

        fresh = 1'b0; START = 1'b0;
        video_on = 1'b0; dino_px = 1'b0; obst_px = 1'b0;
        RESET = 1'b1; cyc();
        RESET = 1'b0; cyc();
        START = 1'b1; cyc();
        START = 1'b0; cyc();
        chk("sat_run", 16'(sat_status), 16'd1);
        for (int f = 1; f <= 10003; f++) begin
            fresh2 = 1'b1; cyc();
            fresh2 = 1'b0; cyc();
            if (f == 1234) chk("sat_1234", sat_score, 16'h1234);
            if (f == 9999) chk("sat_9999", sat_score, 16'h9999);
        end
        chk("sat_hold", sat_score, 16'h9999);
        chk("sat_still_run", 16'(sat_status), 16'd1);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
